// File: rtl/defines_pkg.sv
// Shared types for the pipeline control unit: operand forward selects and
// the halt-drain state encoding.
package defines_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } halt_state_t;

endpackage

// File: rtl/pipe_ctrl_fwd.sv
// Forwarding compare and mux for a single IX operand. MEM has priority over
// WB because it holds the younger producer of the same register.
module pipe_ctrl_fwd
    import defines_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_IDX_W = 3
) (
    input  logic                 i_rd,
    input  logic [REG_IDX_W-1:0] i_idx,
    input  logic                 i_mem_vld,
    input  logic                 i_mem_wr,
    input  logic [REG_IDX_W-1:0] i_mem_idx,
    input  logic                 i_wb_vld,
    input  logic                 i_wb_wr,
    input  logic [REG_IDX_W-1:0] i_wb_idx,
    input  logic [DATA_W-1:0]    i_rf_val,
    input  logic [DATA_W-1:0]    i_mem_val,
    input  logic [DATA_W-1:0]    i_wb_val,
    output fwd_sel_t             o_sel,
    output logic [DATA_W-1:0]    o_val
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_rd && i_mem_vld && i_mem_wr && (i_mem_idx == i_idx);
    assign w_wb_hit  = i_rd && i_wb_vld  && i_wb_wr  && (i_wb_idx  == i_idx);

    // Pick the youngest in-flight producer, else the register file value
    always_comb begin
        o_sel = FWD_RF;
        o_val = i_rf_val;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
            o_val = i_mem_val;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
            o_val = i_wb_val;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 16-bit five-stage core: shadow IX/MEM/WB
// destination tracking, operand forwarding, load-use stall, branch flush and
// halt drain. Optional performance counters are built when PIPE_CTRL_PERF_EN
// is defined; otherwise the counter outputs are tied to zero.
module pipe_ctrl
    import defines_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_IDX_W = 3,
    parameter int PERF_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_valid_ifid_p1,
    input  logic [REG_IDX_W-1:0] rs_idx_id_p1,
    input  logic [REG_IDX_W-1:0] rt_idx_id_p1,
    input  logic                 rs_rd_id_p1,
    input  logic                 rt_rd_id_p1,
    input  logic [REG_IDX_W-1:0] dest_idx_id_p1,
    input  logic                 dest_wr_id_p1,
    input  logic                 is_load_id_p1,
    input  logic                 halt_id_p1,
    input  logic                 branch_taken_ixif_p1,
    input  logic [DATA_W-1:0]    rs_rf_ix_p1,
    input  logic [DATA_W-1:0]    rt_rf_ix_p1,
    input  logic [DATA_W-1:0]    dest_value_ixmem_p1,
    input  logic [DATA_W-1:0]    dest_value_memwb_p1,
    output logic                 stall_if_p1,
    output logic                 stall_id_p1,
    output logic                 bubble_idix_p1,
    output logic                 flush_ifid_p1,
    output logic                 flush_idix_p1,
    output fwd_sel_t             fwd_sel_rs_p1,
    output fwd_sel_t             fwd_sel_rt_p1,
    output logic [DATA_W-1:0]    rs_ix_p1,
    output logic [DATA_W-1:0]    rt_ix_p1,
    output logic                 halt_p1,
    output logic [PERF_W-1:0]    cycle_cnt_p1,
    output logic [PERF_W-1:0]    retire_cnt_p1,
    output logic [PERF_W-1:0]    stall_cnt_p1,
    output logic [PERF_W-1:0]    flush_cnt_p1
);

    // IX shadow entry
    logic                 r_ix_vld, r_ix_wr, r_ix_ld;
    logic [REG_IDX_W-1:0] r_ix_dest, r_ix_rs, r_ix_rt;
    logic                 r_ix_rs_rd, r_ix_rt_rd;
    // MEM/WB shadow entries; is_load is not kept past IX since the load-use
    // stall guarantees nothing ever forwards from a load still in MEM.
    logic                 r_mem_vld, r_mem_wr;
    logic [REG_IDX_W-1:0] r_mem_dest;
    logic                 r_wb_vld, r_wb_wr;
    logic [REG_IDX_W-1:0] r_wb_dest;

    halt_state_t          r_state;
    logic                 r_halt;

    logic w_br;
    logic w_lu;
    logic w_lu_stall;
    logic w_hold;
    logic w_halt_acc;
    logic w_id_adv;

    // A taken branch is ignored once halted; otherwise it always flushes
    assign w_br = branch_taken_ixif_p1 && (r_state != HALTED);

    assign w_lu = inst_valid_ifid_p1 && r_ix_vld && r_ix_ld && r_ix_wr &&
                  ((rs_rd_id_p1 && (rs_idx_id_p1 == r_ix_dest)) ||
                   (rt_rd_id_p1 && (rt_idx_id_p1 == r_ix_dest)));

    // Branch squashes the dependent instruction, so it wins over the stall
    assign w_lu_stall = (r_state == RUN) && w_lu && !w_br;
    assign w_hold     = w_lu_stall || (r_state != RUN);

    assign w_halt_acc = (r_state == RUN) && inst_valid_ifid_p1 && halt_id_p1 && !w_br;

    // HALT itself never enters IX: it is consumed in decode so the drain
    // covers exactly the three older stages.
    assign w_id_adv = inst_valid_ifid_p1 && !w_hold && !w_br && !halt_id_p1;

    assign stall_if_p1    = w_hold;
    assign stall_id_p1    = w_hold;
    assign bubble_idix_p1 = w_hold;
    assign flush_ifid_p1  = w_br;
    assign flush_idix_p1  = w_br;
    assign halt_p1        = r_halt;

    // Shadow pipeline: IX loads decode or a bubble, MEM and WB always shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ix_vld   <= 1'b0;
            r_ix_wr    <= 1'b0;
            r_ix_ld    <= 1'b0;
            r_ix_dest  <= '0;
            r_ix_rs    <= '0;
            r_ix_rt    <= '0;
            r_ix_rs_rd <= 1'b0;
            r_ix_rt_rd <= 1'b0;
            r_mem_vld  <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_dest <= '0;
            r_wb_vld   <= 1'b0;
            r_wb_wr    <= 1'b0;
            r_wb_dest  <= '0;
        end else begin
            if (w_id_adv) begin
                r_ix_vld   <= 1'b1;
                r_ix_wr    <= dest_wr_id_p1;
                r_ix_ld    <= is_load_id_p1;
                r_ix_dest  <= dest_idx_id_p1;
                r_ix_rs    <= rs_idx_id_p1;
                r_ix_rt    <= rt_idx_id_p1;
                r_ix_rs_rd <= rs_rd_id_p1;
                r_ix_rt_rd <= rt_rd_id_p1;
            end else begin
                r_ix_vld   <= 1'b0;
                r_ix_wr    <= 1'b0;
                r_ix_ld    <= 1'b0;
                r_ix_dest  <= '0;
                r_ix_rs    <= '0;
                r_ix_rt    <= '0;
                r_ix_rs_rd <= 1'b0;
                r_ix_rt_rd <= 1'b0;
            end
            r_mem_vld  <= r_ix_vld;
            r_mem_wr   <= r_ix_wr;
            r_mem_dest <= r_ix_dest;
            r_wb_vld   <= r_mem_vld;
            r_wb_wr    <= r_mem_wr;
            r_wb_dest  <= r_mem_dest;
        end
    end

    // Halt FSM: drain the three shadow stages, then halt until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_halt_acc) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!r_ix_vld && !r_mem_vld && !r_wb_vld) begin
                        r_state <= HALTED;
                        r_halt  <= 1'b1;
                    end
                end
                HALTED: begin
                    r_halt <= 1'b1;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    pipe_ctrl_fwd #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) u_fwd_rs (
        .i_rd      (r_ix_rs_rd),
        .i_idx     (r_ix_rs),
        .i_mem_vld (r_mem_vld),
        .i_mem_wr  (r_mem_wr),
        .i_mem_idx (r_mem_dest),
        .i_wb_vld  (r_wb_vld),
        .i_wb_wr   (r_wb_wr),
        .i_wb_idx  (r_wb_dest),
        .i_rf_val  (rs_rf_ix_p1),
        .i_mem_val (dest_value_ixmem_p1),
        .i_wb_val  (dest_value_memwb_p1),
        .o_sel     (fwd_sel_rs_p1),
        .o_val     (rs_ix_p1)
    );

    pipe_ctrl_fwd #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) u_fwd_rt (
        .i_rd      (r_ix_rt_rd),
        .i_idx     (r_ix_rt),
        .i_mem_vld (r_mem_vld),
        .i_mem_wr  (r_mem_wr),
        .i_mem_idx (r_mem_dest),
        .i_wb_vld  (r_wb_vld),
        .i_wb_wr   (r_wb_wr),
        .i_wb_idx  (r_wb_dest),
        .i_rf_val  (rt_rf_ix_p1),
        .i_mem_val (dest_value_ixmem_p1),
        .i_wb_val  (dest_value_memwb_p1),
        .o_sel     (fwd_sel_rt_p1),
        .o_val     (rt_ix_p1)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] r_cycle_cnt, r_retire_cnt, r_stall_cnt, r_flush_cnt;

    // Free-running event counters, wrapping naturally at 2^PERF_W
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (r_state != HALTED) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (r_wb_vld)          r_retire_cnt <= r_retire_cnt + 1'b1;
            if (w_lu_stall)        r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_br)              r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign cycle_cnt_p1  = r_cycle_cnt;
    assign retire_cnt_p1 = r_retire_cnt;
    assign stall_cnt_p1  = r_stall_cnt;
    assign flush_cnt_p1  = r_flush_cnt;
`else
    assign cycle_cnt_p1  = '0;
    assign retire_cnt_p1 = '0;
    assign stall_cnt_p1  = '0;
    assign flush_cnt_p1  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of per-cycle decode vectors with
// expected hazard and forward outputs, then hand sequences for branch vs
// load-use, halt drain timing, halt squashed by branch and reset mid-drain.
module tb_pipe_ctrl;
    import defines_pkg::*;

    localparam int DATA_W = 16;
    localparam int RW     = 3;
    localparam int PW     = 32;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [15:0] RS_RF = 16'h1111;
    localparam logic [15:0] RT_RF = 16'h2222;
    localparam logic [15:0] V_MEM = 16'h0005;
    localparam logic [15:0] V_WB  = 16'hBEEF;

    logic clk = 1'b0;
    logic rst;
    logic inst_valid, rs_rd, rt_rd, dest_wr, is_load, halt_id, br;
    logic [RW-1:0] rs_idx, rt_idx, dest_idx;
    logic [DATA_W-1:0] rs_rf, rt_rf, v_mem, v_wb;
    logic stall_if, stall_id, bubble, flush_ifid, flush_idix, halt_o;
    fwd_sel_t sel_rs, sel_rt;
    logic [DATA_W-1:0] rs_ix, rt_ix;
    logic [PW-1:0] cyc_cnt, ret_cnt, stl_cnt, fl_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.DATA_W(DATA_W), .REG_IDX_W(RW), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_ifid_p1(inst_valid),
        .rs_idx_id_p1(rs_idx), .rt_idx_id_p1(rt_idx),
        .rs_rd_id_p1(rs_rd), .rt_rd_id_p1(rt_rd),
        .dest_idx_id_p1(dest_idx), .dest_wr_id_p1(dest_wr),
        .is_load_id_p1(is_load), .halt_id_p1(halt_id),
        .branch_taken_ixif_p1(br),
        .rs_rf_ix_p1(rs_rf), .rt_rf_ix_p1(rt_rf),
        .dest_value_ixmem_p1(v_mem), .dest_value_memwb_p1(v_wb),
        .stall_if_p1(stall_if), .stall_id_p1(stall_id),
        .bubble_idix_p1(bubble),
        .flush_ifid_p1(flush_ifid), .flush_idix_p1(flush_idix),
        .fwd_sel_rs_p1(sel_rs), .fwd_sel_rt_p1(sel_rt),
        .rs_ix_p1(rs_ix), .rt_ix_p1(rt_ix),
        .halt_p1(halt_o),
        .cycle_cnt_p1(cyc_cnt), .retire_cnt_p1(ret_cnt),
        .stall_cnt_p1(stl_cnt), .flush_cnt_p1(fl_cnt)
    );

    typedef struct {
        logic          v;
        logic [RW-1:0] rs;
        logic          rsr;
        logic [RW-1:0] rt;
        logic          rtr;
        logic [RW-1:0] dst;
        logic          dwr;
        logic          ld;
        logic          brk;
        logic          e_stall;
        logic          e_flush;
        logic [1:0]    e_srs;
        logic [1:0]    e_srt;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic v, input int rs, input logic rsr,
                                input int rt, input logic rtr, input int dst,
                                input logic dwr, input logic ld, input logic brk,
                                input logic es, input logic ef,
                                input int esr, input int est);
        vec_t r;
        r.v = v; r.rs = RW'(rs); r.rsr = rsr; r.rt = RW'(rt); r.rtr = rtr;
        r.dst = RW'(dst); r.dwr = dwr; r.ld = ld; r.brk = brk;
        r.e_stall = es; r.e_flush = ef; r.e_srs = 2'(esr); r.e_srt = 2'(est);
        return r;
    endfunction

    function automatic logic [15:0] val_of(input logic [1:0] s, input logic [15:0] rf);
        if (s == 2'b01) return V_MEM;
        if (s == 2'b10) return V_WB;
        return rf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        inst_valid = 0; rs_idx = 0; rt_idx = 0; rs_rd = 0; rt_rd = 0;
        dest_idx = 0; dest_wr = 0; is_load = 0; halt_id = 0; br = 0;
    endtask

    task automatic drive(input vec_t r);
        inst_valid = r.v; rs_idx = r.rs; rs_rd = r.rsr; rt_idx = r.rt;
        rt_rd = r.rtr; dest_idx = r.dst; dest_wr = r.dwr; is_load = r.ld;
        halt_id = 1'b0; br = r.brk;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rs_rf = RS_RF; rt_rf = RT_RF; v_mem = V_MEM; v_wb = V_WB;
        //           v rs rsr rt rtr dst dwr ld br | stall flush srs srt
        vecs[0]  = mk(1, 3, 1, 4, 1, 1, 1, 0, 0,  0, 0, 0, 0); // ADD R1
        vecs[1]  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 0, 0); // ADD R5 <- R1
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0); // IX reads R1 from MEM
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[4]  = mk(1, 6, 1, 0, 0, 2, 1, 1, 0,  0, 0, 0, 0); // LD R2
        vecs[5]  = mk(1, 2, 1, 2, 1, 7, 1, 0, 0,  1, 0, 0, 0); // load-use stall
        vecs[6]  = mk(1, 2, 1, 2, 1, 7, 1, 0, 0,  0, 0, 0, 0); // held ADD advances
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 2); // load data from WB
        vecs[8]  = mk(1, 3, 1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0); // ADD R0
        vecs[9]  = mk(1, 0, 1, 0, 0, 4, 0, 0, 0,  0, 0, 0, 0); // reads R0, rt unread
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0); // R0 forwarded
        vecs[11] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0); // R3 older
        vecs[12] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0); // R3 younger
        vecs[13] = mk(1, 3, 1, 3, 1, 6, 1, 0, 0,  0, 0, 0, 0); // reads R3 twice
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1); // MEM beats WB
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        do_reset();
        // Reset state (sampled just after release; nothing clocked in yet)
        chk("rst stall_if", stall_if, 0);
        chk("rst bubble", bubble, 0);
        chk("rst flush", {flush_ifid, flush_idix}, 0);
        chk("rst sel", {sel_rs, sel_rt}, 0);
        chk("rst rs_ix", rs_ix, RS_RF);
        chk("rst rt_ix", rt_ix, RT_RF);
        chk("rst halt", halt_o, 0);
        chk("rst cnt", cyc_cnt | ret_cnt | stl_cnt | fl_cnt, 0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("row%0d stall_if", i), stall_if, vecs[i].e_stall);
            chk($sformatf("row%0d stall_id", i), stall_id, vecs[i].e_stall);
            chk($sformatf("row%0d bubble", i), bubble, vecs[i].e_stall);
            chk($sformatf("row%0d flush", i), {flush_ifid, flush_idix}, {2{vecs[i].e_flush}});
            chk($sformatf("row%0d sel_rs", i), sel_rs, vecs[i].e_srs);
            chk($sformatf("row%0d sel_rt", i), sel_rt, vecs[i].e_srt);
            chk($sformatf("row%0d rs_ix", i), rs_ix, val_of(vecs[i].e_srs, RS_RF));
            chk($sformatf("row%0d rt_ix", i), rt_ix, val_of(vecs[i].e_srt, RT_RF));
            tick();
        end
        chk("table stall_cnt", stl_cnt, PERF ? 1 : 0);

        // Load-use hazard coinciding with a taken branch
        drive(mk(1, 6, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        tick();
        drive(mk(1, 2, 1, 2, 1, 7, 1, 0, 1, 0, 0, 0, 0));
        #1;
        chk("lu+br stall_if", stall_if, 0);
        chk("lu+br stall_id", stall_id, 0);
        chk("lu+br bubble", bubble, 0);
        chk("lu+br flush_ifid", flush_ifid, 1);
        chk("lu+br flush_idix", flush_idix, 1);
        tick();
        idle_in();
        #1;
        chk("lu+br flush_cnt", fl_cnt, PERF ? 1 : 0);
        chk("lu+br stall_cnt", stl_cnt, PERF ? 1 : 0);

        // HALT squashed by a same-cycle branch is ignored
        inst_valid = 1; halt_id = 1; br = 1;
        #1;
        chk("halt+br flush", {flush_ifid, flush_idix}, 2'b11);
        tick();
        idle_in();
        #1;
        chk("halt+br stall_if", stall_if, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("halt+br halt_p1", halt_o, 0);
        chk("halt+br stall_id", stall_id, 0);

        // HALT at cycle 10 with a full pipeline -> halt_p1 at cycle 14
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
            tick();
        end
        inst_valid = 1; halt_id = 1;
        #1;
        chk("c10 stall_if", stall_if, 0);
        tick();
        drive(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int c = 11; c < 14; c++) begin
            #1;
            chk($sformatf("c%0d drain stall_if", c), stall_if, 1);
            chk($sformatf("c%0d drain bubble", c), bubble, 1);
            chk($sformatf("c%0d halt_p1", c), halt_o, 0);
            tick();
        end
        #1;
        chk("c14 halt_p1", halt_o, 1);
        chk("c14 stall_if", stall_if, 1);
        chk("c14 cycle_cnt", cyc_cnt, PERF ? 14 : 0);
        chk("c14 retire_cnt", ret_cnt, PERF ? 10 : 0);
        br = 1;
        #1;
        chk("halted br flush", {flush_ifid, flush_idix}, 0);
        for (int c = 14; c < 18; c++) tick();
        chk("c18 halt_p1", halt_o, 1);
        chk("c18 stall_if", stall_if, 1);
        chk("c18 cycle_cnt", cyc_cnt, PERF ? 14 : 0);

        // Reset during DRAIN returns to RUN and the pipeline resumes
        do_reset();
        inst_valid = 1; halt_id = 1;
        tick();
        idle_in();
        #1;
        chk("drain stall_if", stall_if, 1);
        rst = 1;
        tick();
        chk("mid-rst stall_if", stall_if, 0);
        chk("mid-rst bubble", bubble, 0);
        chk("mid-rst halt", halt_o, 0);
        chk("mid-rst sel", {sel_rs, sel_rt}, 0);
        chk("mid-rst rs_ix", rs_ix, RS_RF);
        chk("mid-rst cnt", cyc_cnt | stl_cnt | fl_cnt | ret_cnt, 0);
        rst = 0;
        drive(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        #1;
        chk("resume stall_id", stall_id, 0);
        tick();
        drive(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0));
        tick();
        idle_in();
        #1;
        chk("resume sel_rs", sel_rs, 2'b01);
        chk("resume rs_ix", rs_ix, V_MEM);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the 16-bit five-stage core (fetch, decode, execute, mem, writeback). It tracks a shadow copy of register-destination and operand information for every in-flight instruction. From that state it produces operand-forwarding selects, load-use stalls, branch flushes and a halt-drain sequence, none of which the current pipeline has. It sits beside decode and execute in the core top level.

## Interface
Parameters:
- DATA_W, 16, datapath width; applies to forwarded values and the IX operand outputs
- REG_IDX_W, 3, register index width
- PERF_W, 32, performance counter width

Ports (`fwd_sel_t` is 2 bits):
- clk  in  1  core clock; one clock domain
- rst  in  1  synchronous, active-high reset
- inst_valid_ifid_p1  in  1  decode holds a valid instruction
- rs_idx_id_p1, rt_idx_id_p1  in  REG_IDX_W  decode source indices
- rs_rd_id_p1, rt_rd_id_p1  in  1  the source is actually read
- dest_idx_id_p1  in  REG_IDX_W  decode destination index
- dest_wr_id_p1  in  1  the decode instruction writes a register
- is_load_id_p1  in  1  the decode instruction is a load
- halt_id_p1  in  1  decode holds HALT
- branch_taken_ixif_p1  in  1  execute resolved a taken branch or jump
- rs_rf_ix_p1, rt_rf_ix_p1  in  DATA_W  register-file operands latched into IX
- dest_value_ixmem_p1  in  DATA_W  IX/MEM result
- dest_value_memwb_p1  in  DATA_W  MEM/WB result, including load data
- stall_if_p1, stall_id_p1  out  1  hold the PC and the IF/ID latch
- bubble_idix_p1  out  1  load a NOP into ID/IX
- flush_ifid_p1, flush_idix_p1  out  1  squash the younger instructions
- fwd_sel_rs_p1, fwd_sel_rt_p1  out  fwd_sel_t  IX operand source
- rs_ix_p1, rt_ix_p1  out  DATA_W  forwarded IX operands
- halt_p1  out  1  pipeline drained and halted
- cycle_cnt_p1, retire_cnt_p1, stall_cnt_p1, flush_cnt_p1  out  PERF_W  performance counters

## Operation
- Shadow stages IX, MEM and WB each hold: valid, dest_idx, dest_wr, is_load. IX additionally holds rs/rt index and read flags.
- ID advances when `inst_valid_ifid_p1 & !stall_id_p1 & !flush_idix_p1`. IX then loads the decode fields; otherwise IX loads a bubble (valid=0).
- MEM<=IX and WB<=MEM every cycle. Nothing beyond IX ever stalls.
- Load-use hazard: IX.valid & IX.is_load & IX.dest_wr, and the IX destination matches a read decode source. Response: stall_if, stall_id and bubble_idix all assert for exactly one cycle.
- Forwarding, evaluated per operand on the IX shadow entry, in priority order:
  - MEM.valid & dest_wr & index match → FWD_MEM (value dest_value_ixmem)
  - else WB.valid & dest_wr & index match → FWD_WB (value dest_value_memwb)
  - else FWD_RF (value rs/rt_rf)
  - An operand whose read flag is clear always gets FWD_RF.
- Branch: branch_taken_ixif_p1 asserts flush_ifid and flush_idix in the same cycle. Branch overrides a load-use stall: no stall and no bubble that cycle.
- Halt FSM:
  - RUN → DRAIN when halt_id_p1 is accepted, i.e. valid and not flushed. A halt flushed by a same-cycle branch is ignored.
  - DRAIN: stall_if and stall_id held at 1, bubble_idix held at 1.
  - DRAIN → HALTED once IX, MEM and WB valid are all 0.
  - HALTED: halt_p1=1 and stalls held until rst. Branch input ignored.
- Register R0 is general-purpose and is forwarded like any other register.

## Timing
- Reset value of every output is 0: stalls, bubble, flushes, fwd_sel=FWD_RF, halt_p1, all counters. rs/rt_ix pass rs/rt_rf through.
- Reset clears all shadow valids and puts the FSM in RUN. A mid-drain reset returns to RUN the next cycle.
- Stalls, flushes and bubble are combinational from the current-cycle inputs and shadow state.
- fwd_sel and the operand outputs are combinational from registered shadow state. No added latency.
- HALT in decode at cycle t → halt_p1 rises at t+4 (drain of 3 stages plus the FSM register).

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - cycle_cnt increments every cycle outside HALTED.
  - retire_cnt increments when WB.valid.
  - stall_cnt increments on each load-use stall cycle.
  - flush_cnt increments on each branch flush.
  - All counters wrap modulo 2^PERF_W and clear on rst.
- PIPE_CTRL_PERF_EN undefined: counter registers are absent and all counter outputs are tied to 0.

## Structure
- defines_pkg gains:
  - `fwd_sel_t` enum: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - `halt_state_t` enum: RUN, DRAIN, HALTED
- Sub-module pipe_ctrl_fwd: combinational comparison and mux for one operand, instantiated once for rs and once for rt.

## Test plan
- ADD R1 then ADD using R1 back-to-back → fwd_sel_rs=FWD_MEM, rs_ix = IX/MEM value 16'h0005; no stall.
- LD R2 then ADD reading R2 → exactly one stall and bubble cycle, then fwd_sel=FWD_WB with load data 16'hBEEF; stall_cnt=1.
- Load-use hazard and branch_taken in the same cycle → both flushes =1, stall=0, bubble=0; flush_cnt=1.
- HALT at cycle 10 → halt_p1=1 at cycle 14 and held; stall_if stays 1; cycle_cnt freezes.
- HALT in decode with a same-cycle taken branch → FSM stays RUN and halt_p1 stays 0.
- rst asserted during DRAIN → next cycle all outputs are 0, FSM is RUN, and the pipeline resumes fetching.
